// File: rtl/pc_sequencer_pkg.sv
// Shared constants and state encoding for the fetch PC sequencer.
package pc_sequencer_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;
    localparam logic [31:0] PC_STEP      = 32'd4;

    typedef enum logic {
        RUN  = 1'b0,
        PEND = 1'b1
    } state_t;

endpackage

// File: rtl/pc_sequencer_inc.sv
// 32-bit +4 incrementer; wraps modulo 2^32 with no carry out.
module pc_sequencer_inc
    import pc_sequencer_pkg::*;
(
    input  logic [31:0] a,
    output logic [31:0] y
);

    assign y = a + PC_STEP;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch PC register with next-PC selection, stall hold and deferred redirect.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [31:0] pc_plus8,
    output logic        redirect_pending,
    output logic        pc_adel
);

    state_t      state;
    logic [31:0] pend_target;

    pc_sequencer_inc u_inc4 (
        .a (pc),
        .y (pc_plus4)
    );

    // Link address for jal/jalr comes from chaining a second incrementer.
    pc_sequencer_inc u_inc8 (
        .a (pc_plus4),
        .y (pc_plus8)
    );

    // CP0 redirects override stall; a D-stage redirect during stall is parked.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc          <= RESET_PC;
            state       <= RUN;
            pend_target <= '0;
        end else if (exc_req) begin
            pc    <= EXC_VEC;
            state <= RUN;
        end else if (eret_req) begin
            pc    <= epc;
            state <= RUN;
        end else if (stall) begin
            if (br_taken || jmp_valid) begin
                pend_target <= jmp_valid ? jmp_target : br_target;
                state       <= PEND;
            end
        end else if (jmp_valid) begin
            pc    <= jmp_target;
            state <= RUN;
        end else if (br_taken) begin
            pc    <= br_target;
            state <= RUN;
        end else if (state == PEND) begin
            pc    <= pend_target;
            state <= RUN;
        end else begin
            pc <= pc_plus4;
        end
    end

    assign redirect_pending = (state == PEND);
    assign pc_adel          = (pc[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: driver queues expected PC state, monitor checks it.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, br_taken, jmp_valid, exc_req, eret_req;
    logic [31:0] br_target, jmp_target, epc;
    logic [31:0] pc, pc_plus4, pc_plus8;
    logic        redirect_pending, pc_adel;

    typedef struct {
        logic [31:0] pc;
        logic        pend;
        logic        imm;
        string       nm;
    } exp_t;

    exp_t exp_q[$];
    event chk_ev;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .br_taken         (br_taken),
        .br_target        (br_target),
        .jmp_valid        (jmp_valid),
        .jmp_target       (jmp_target),
        .exc_req          (exc_req),
        .eret_req         (eret_req),
        .epc              (epc),
        .pc               (pc),
        .pc_plus4         (pc_plus4),
        .pc_plus8         (pc_plus8),
        .redirect_pending (redirect_pending),
        .pc_adel          (pc_adel)
    );

    task automatic check32(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    task automatic check1(input string nm, input logic act, input logic req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %b expected %b", nm, act, req);
        end
    endtask

    // Monitor: compares one queued expectation after each clock edge or immediate check.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or chk_ev);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check32({e.nm, ".pc"}, pc, e.pc);
                check32({e.nm, ".pc_plus4"}, pc_plus4, e.pc + 32'd4);
                check32({e.nm, ".pc_plus8"}, pc_plus8, e.pc + 32'd8);
                check1({e.nm, ".pending"}, redirect_pending, e.pend);
                check1({e.nm, ".pc_adel"}, pc_adel, e.pc[1:0] != 2'b00);
            end
        end
    end

    // Decode-error guard: jump and branch must never be requested together.
    always @(posedge clk) begin
        if (!reset && br_taken && jmp_valid) begin
            bad++;
            $display("FAIL decode_conflict: br_taken=%b jmp_valid=%b expected not both", br_taken, jmp_valid);
        end
    end

    // Called at a negedge: drive inputs for the next edge, queue the state expected after it.
    task automatic drv(input logic s, input logic b, input logic j, input logic x,
                       input logic r, input logic [31:0] tgt,
                       input logic [31:0] exp_pc, input logic exp_pend, input string nm);
        exp_t e;
        stall = s; br_taken = b; jmp_valid = j; exc_req = x; eret_req = r;
        br_target = tgt; jmp_target = tgt; epc = tgt;
        e.pc = exp_pc; e.pend = exp_pend; e.imm = 1'b0; e.nm = nm;
        exp_q.push_back(e);
        @(negedge clk);
    endtask

    task automatic imm_check(input logic [31:0] exp_pc, input logic exp_pend, input string nm);
        exp_t e;
        e.pc = exp_pc; e.pend = exp_pend; e.imm = 1'b1; e.nm = nm;
        exp_q.push_back(e);
        -> chk_ev;
        #2;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        stall = 0; br_taken = 0; jmp_valid = 0; exc_req = 0; eret_req = 0;
        br_target = '0; jmp_target = '0; epc = '0;
        @(negedge clk);
        imm_check(32'h0000_3000, 1'b0, "reset");
        reset = 1'b0;

        // free-running sequence
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_3004, 0, "seq1");
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_3008, 0, "seq2");
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_300C, 0, "seq3");
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_3010, 0, "seq4");
        // branch taken, no stall
        drv(0, 1, 0, 0, 0, 32'h0000_3100, 32'h0000_3100, 0, "branch");
        drv(0, 0, 1, 0, 0, 32'h0000_3020, 32'h0000_3020, 0, "jump");
        // jump during a three-cycle stall
        drv(1, 0, 1, 0, 0, 32'h0000_3400, 32'h0000_3020, 1, "stall_jmp1");
        drv(1, 0, 0, 0, 0, 32'h0, 32'h0000_3020, 1, "stall_jmp2");
        drv(1, 0, 0, 0, 0, 32'h0, 32'h0000_3020, 1, "stall_jmp3");
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_3400, 0, "pend_apply");
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_3404, 0, "after_pend");
        // exception preempts a pending redirect
        drv(1, 0, 1, 0, 0, 32'h0000_3400, 32'h0000_3404, 1, "pend_again");
        drv(1, 0, 0, 1, 0, 32'h0, 32'h0000_4180, 0, "exc_in_pend");
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_4184, 0, "after_exc");
        // eret during stall
        drv(1, 0, 0, 0, 1, 32'h0000_3050, 32'h0000_3050, 0, "eret_stall");
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_3054, 0, "after_eret");
        // last writer wins in PEND
        drv(1, 1, 0, 0, 0, 32'h0000_3200, 32'h0000_3054, 1, "pend_br");
        drv(1, 0, 1, 0, 0, 32'h0000_3300, 32'h0000_3054, 1, "pend_overwrite");
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_3300, 0, "overwrite_apply");
        // fresh branch beats a pending target
        drv(1, 1, 0, 0, 0, 32'h0000_3500, 32'h0000_3300, 1, "pend_br2");
        drv(0, 1, 0, 0, 0, 32'h0000_3600, 32'h0000_3600, 0, "fresh_br_wins");
        // exception beats eret
        drv(0, 0, 0, 1, 1, 32'h0000_3700, 32'h0000_4180, 0, "exc_over_eret");
        // wrap and misalignment
        drv(0, 0, 1, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 0, "wrap_jmp");
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_0000, 0, "wrap_seq");
        drv(0, 0, 1, 0, 0, 32'h0000_3002, 32'h0000_3002, 0, "misalign_jmp");
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_3006, 0, "misalign_seq");
        // async reset in PEND
        drv(1, 1, 0, 0, 0, 32'h0000_3700, 32'h0000_3006, 1, "pend_before_rst");
        #1;
        reset = 1'b1;
        imm_check(32'h0000_3000, 1'b0, "async_reset");
        stall = 0; br_taken = 0;
        @(negedge clk);
        reset = 1'b0;
        drv(0, 0, 0, 0, 0, 32'h0, 32'h0000_3004, 0, "post_reset");

        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d queued expectations, expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
